// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetromino piece path.
package tetris_pkg;

   typedef logic [2:0] piece_t;

   localparam int     NUM_PIECES = 7;
   localparam piece_t PIECE_NONE = 3'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CAPT = 2'd2
   } refill_state_t;

   // Out-of-range generator codes (only 3'd7 fits in 3 bits) are mapped to PIECE_NONE.
   function automatic piece_t sanitise_piece(input piece_t raw);
      return (raw >= piece_t'(NUM_PIECES)) ? PIECE_NONE : raw;
   endfunction

endpackage

// File: rtl/piece_queue_if.sv
// Spawn/hold handshake, preview/hold status and generator handshake of piece_queue.
interface piece_queue_if #(parameter int DEPTH = 3);
   import tetris_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                 spawn_req;
   logic                 hold_req;
   logic                 spawn_ack;
   piece_t               piece_idx;
   piece_t [DEPTH-1:0]   preview_idx;
   logic [CNT_W-1:0]     preview_cnt;
   piece_t               hold_idx;
   logic                 hold_valid;
   logic                 hold_allowed;
   logic                 gen_new_block;
   piece_t               gen_block_idx;

   // Game FSM plus generator side.
   modport master (
      output spawn_req, hold_req, gen_block_idx,
      input  spawn_ack, piece_idx, preview_idx, preview_cnt,
             hold_idx, hold_valid, hold_allowed, gen_new_block
   );

   // piece_queue side.
   modport slave (
      input  spawn_req, hold_req, gen_block_idx,
      output spawn_ack, piece_idx, preview_idx, preview_cnt,
             hold_idx, hold_valid, hold_allowed, gen_new_block
   );

endinterface

// File: rtl/piece_fifo.sv
// Shift-register preview FIFO: entry 0 is the head, pop shifts everything down,
// a push lands at the first free slot (or the slot vacated by a same-cycle pop).
module piece_fifo
   import tetris_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  piece_t                       din,
   input  logic                         pop,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output piece_t [DEPTH-1:0]           contents
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   piece_t [DEPTH-1:0] entry_reg;
   piece_t [DEPTH-1:0] entry_next;
   logic [CNT_W-1:0]   count_reg;
   logic [CNT_W-1:0]   count_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         piece_t shifted;
         logic   load_here;

         if (gi == DEPTH - 1) begin : g_last
            assign shifted = PIECE_NONE;
         end else begin : g_body
            assign shifted = entry_reg[gi+1];
         end

         // With a pop the tail slot moves down by one, so the push lands one lower.
         assign load_here = push && (pop ? (count_reg == CNT_W'(gi + 1))
                                         : (count_reg == CNT_W'(gi)));

         assign entry_next[gi] = load_here ? din : (pop ? shifted : entry_reg[gi]);
      end
   endgenerate

   // Occupancy: push and pop together leave it unchanged.
   always_comb begin
      count_next = count_reg;
      if (push && !pop && count_reg != CNT_W'(DEPTH))
         count_next = count_reg + CNT_W'(1);
      else if (pop && !push && count_reg != '0)
         count_next = count_reg - CNT_W'(1);
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_reg <= '0;
         count_reg <= '0;
      end else begin
         entry_reg <= entry_next;
         count_reg <= count_next;
      end
   end

   assign count    = count_reg;
   assign contents = entry_reg;

endmodule

// File: rtl/piece_queue.sv
// Consumer end of the tetromino generator: keeps the preview FIFO topped up,
// serves spawn requests and owns the single hold slot.
module piece_queue
   import tetris_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic             Clk,
   input  logic             Reset_n,
   piece_queue_if.slave     bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   refill_state_t      state_reg;
   logic               gen_new_block_reg;

   logic [CNT_W-1:0]   fifo_count;
   piece_t [DEPTH-1:0] fifo_contents;
   logic               fifo_push;
   logic               fifo_pop;
   logic [CNT_W-1:0]   count_after_pop;

   logic               spawn_ack_reg;
   piece_t             piece_idx_reg;
   piece_t             hold_idx_reg;
   logic               hold_valid_reg;
   logic               hold_allowed_reg;
   logic               hold_pop_pending_reg;

   logic               have_piece;
   logic               pop_req;
   logic               spawn_take;
   logic               hold_take;

   // A hold into an empty slot needs a pop; if the FIFO was empty that pop waits here.
   assign have_piece = (fifo_count != '0);
   assign pop_req    = bus.spawn_req || hold_pop_pending_reg;
   // Blocking on spawn_ack keeps acks at least one idle cycle apart.
   assign spawn_take = pop_req && have_piece && !spawn_ack_reg;
   assign hold_take  = bus.hold_req && hold_allowed_reg && !spawn_ack_reg && !spawn_take;

   assign fifo_push       = (state_reg == CAPT);
   assign fifo_pop        = spawn_take || (hold_take && !hold_valid_reg && have_piece);
   assign count_after_pop = fifo_count - CNT_W'(fifo_pop);

   piece_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .push     (fifo_push),
      .din      (sanitise_piece(bus.gen_block_idx)),
      .pop      (fifo_pop),
      .count    (fifo_count),
      .contents (fifo_contents)
   );

   // Refill FSM: one generator request in flight until the FIFO is full.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg         <= REQ;
         gen_new_block_reg <= 1'b0;
      end else begin
         unique case (state_reg)
            REQ: begin
               gen_new_block_reg <= 1'b1;
               state_reg         <= CAPT;
            end
            CAPT: begin
               gen_new_block_reg <= 1'b0;
               state_reg         <= (int'(count_after_pop) + 1 < DEPTH) ? REQ : IDLE;
            end
            IDLE: begin
               gen_new_block_reg <= 1'b0;
               if (int'(count_after_pop) < DEPTH)
                  state_reg <= REQ;
            end
            default: begin
               gen_new_block_reg <= 1'b0;
               state_reg         <= REQ;
            end
         endcase
      end
   end

   // Active piece, hold slot and spawn acknowledge; spawn wins over hold.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         spawn_ack_reg        <= 1'b0;
         piece_idx_reg        <= PIECE_NONE;
         hold_idx_reg         <= PIECE_NONE;
         hold_valid_reg       <= 1'b0;
         hold_allowed_reg     <= 1'b1;
         hold_pop_pending_reg <= 1'b0;
      end else begin
         spawn_ack_reg <= 1'b0;
         if (spawn_take) begin
            piece_idx_reg        <= fifo_contents[0];
            spawn_ack_reg        <= 1'b1;
            hold_pop_pending_reg <= 1'b0;
            // A pop that finishes a hold keeps the hold locked for this piece.
            if (bus.spawn_req)
               hold_allowed_reg <= 1'b1;
         end else if (hold_take) begin
            hold_allowed_reg <= 1'b0;
            if (hold_valid_reg) begin
               piece_idx_reg <= hold_idx_reg;
               hold_idx_reg  <= piece_idx_reg;
               spawn_ack_reg <= 1'b1;
            end else begin
               hold_idx_reg   <= piece_idx_reg;
               hold_valid_reg <= 1'b1;
               if (have_piece) begin
                  piece_idx_reg <= fifo_contents[0];
                  spawn_ack_reg <= 1'b1;
               end else begin
                  hold_pop_pending_reg <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.spawn_ack     = spawn_ack_reg;
   assign bus.piece_idx     = piece_idx_reg;
   assign bus.preview_idx   = fifo_contents;
   assign bus.preview_cnt   = fifo_count;
   assign bus.hold_idx      = hold_idx_reg;
   assign bus.hold_valid    = hold_valid_reg;
   assign bus.hold_allowed  = hold_allowed_reg;
   assign bus.gen_new_block = gen_new_block_reg;

endmodule

// File: tb/tb_piece_queue.sv
// Directed testbench for piece_queue with a scripted generator model.
module tb_piece_queue;
   import tetris_pkg::*;

   localparam int DEPTH = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   piece_t gen_q[$];
   logic   gen_pend = 1'b0;
   piece_t [DEPTH-1:0] exp_prev;

   piece_queue_if #(.DEPTH(DEPTH)) bus ();

   piece_queue #(.DEPTH(DEPTH)) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Generator: presents the next scripted value; a seen new_block consumes it.
   always @(posedge clk) begin
      #1;
      if (gen_pend && gen_q.size() > 0)
         gen_q.delete(0);
      gen_pend = bus.gen_new_block;
      bus.gen_block_idx = (gen_q.size() > 0) ? gen_q[0] : 3'd3;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      bus.spawn_req = 1'b0;
      bus.hold_req  = 1'b0;
      step();
      step();
      gen_q.delete();
   endtask

   task automatic test_reset();
      hold_reset();
      $display("reset: ack=%0d piece=%0d cnt=%0d hv=%0d ha=%0d nb=%0d",
               bus.spawn_ack, bus.piece_idx, bus.preview_cnt, bus.hold_valid,
               bus.hold_allowed, bus.gen_new_block);
      total++; if (bus.spawn_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0d want=0", bus.spawn_ack); end
      total++; if (bus.piece_idx !== 3'd0) begin bad++; $display("FAIL reset_piece got=%0d want=0", bus.piece_idx); end
      total++; if (bus.preview_idx !== 9'd0) begin bad++; $display("FAIL reset_preview got=%h want=0", bus.preview_idx); end
      total++; if (bus.preview_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.preview_cnt); end
      total++; if (bus.hold_idx !== 3'd0) begin bad++; $display("FAIL reset_hold_idx got=%0d want=0", bus.hold_idx); end
      total++; if (bus.hold_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%0d want=0", bus.hold_valid); end
      total++; if (bus.hold_allowed !== 1'b1) begin bad++; $display("FAIL reset_hold_allowed got=%0d want=1", bus.hold_allowed); end
      total++; if (bus.gen_new_block !== 1'b0) begin bad++; $display("FAIL reset_new_block got=%0d want=0", bus.gen_new_block); end
   endtask

   task automatic test_reset_fill();
      hold_reset();
      gen_q = '{3'd4, 3'd1, 3'd6, 3'd3, 3'd3, 3'd3};
      rst_n = 1'b1;
      step();
      total++; if (bus.gen_new_block !== 1'b1) begin bad++; $display("FAIL fill_first_req got=%0d want=1", bus.gen_new_block); end
      step();
      total++; if (bus.preview_cnt !== 2'd1) begin bad++; $display("FAIL fill_cnt1 got=%0d want=1", bus.preview_cnt); end
      total++; if (bus.preview_idx[0] !== 3'd4) begin bad++; $display("FAIL fill_entry0 got=%0d want=4", bus.preview_idx[0]); end
      total++; if (bus.gen_new_block !== 1'b0) begin bad++; $display("FAIL fill_pulse_len got=%0d want=0", bus.gen_new_block); end
      repeat (4) step();
      exp_prev = {3'd6, 3'd1, 3'd4};
      $display("fill: preview=%h cnt=%0d", bus.preview_idx, bus.preview_cnt);
      total++; if (bus.preview_cnt !== 2'd3) begin bad++; $display("FAIL fill_cnt3 got=%0d want=3", bus.preview_cnt); end
      total++; if (bus.preview_idx !== exp_prev) begin bad++; $display("FAIL fill_preview got=%h want=%h", bus.preview_idx, exp_prev); end
      step();
      total++; if (bus.gen_new_block !== 1'b0) begin bad++; $display("FAIL fill_idle got=%0d want=0", bus.gen_new_block); end
   endtask

   task automatic test_spawn();
      hold_reset();
      gen_q = '{3'd4, 3'd1, 3'd6, 3'd3, 3'd5, 3'd5};
      rst_n = 1'b1;
      repeat (7) step();
      bus.spawn_req = 1'b1;
      step();
      bus.spawn_req = 1'b0;
      $display("spawn: ack=%0d piece=%0d cnt=%0d preview=%h", bus.spawn_ack, bus.piece_idx, bus.preview_cnt, bus.preview_idx);
      total++; if (bus.spawn_ack !== 1'b1) begin bad++; $display("FAIL spawn_ack got=%0d want=1", bus.spawn_ack); end
      total++; if (bus.piece_idx !== 3'd4) begin bad++; $display("FAIL spawn_piece got=%0d want=4", bus.piece_idx); end
      total++; if (bus.preview_cnt !== 2'd2) begin bad++; $display("FAIL spawn_cnt got=%0d want=2", bus.preview_cnt); end
      total++; if (bus.preview_idx[0] !== 3'd1 || bus.preview_idx[1] !== 3'd6) begin bad++; $display("FAIL spawn_shift got=%h want=x61", bus.preview_idx); end
      step();
      total++; if (bus.spawn_ack !== 1'b0) begin bad++; $display("FAIL spawn_ack_single got=%0d want=0", bus.spawn_ack); end
      step();
      total++; if (bus.preview_cnt !== 2'd3) begin bad++; $display("FAIL spawn_refill_cnt got=%0d want=3", bus.preview_cnt); end
      total++; if (bus.preview_idx[2] !== 3'd3) begin bad++; $display("FAIL spawn_refill_tail got=%0d want=3", bus.preview_idx[2]); end
   endtask

   task automatic test_empty_stall();
      hold_reset();
      gen_q = '{3'd5, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
      bus.spawn_req = 1'b1;
      rst_n = 1'b1;
      step();
      total++; if (bus.spawn_ack !== 1'b0) begin bad++; $display("FAIL stall_ack_e1 got=%0d want=0", bus.spawn_ack); end
      step();
      total++; if (bus.spawn_ack !== 1'b0) begin bad++; $display("FAIL stall_ack_e2 got=%0d want=0", bus.spawn_ack); end
      step();
      bus.spawn_req = 1'b0;
      $display("stall: ack=%0d piece=%0d", bus.spawn_ack, bus.piece_idx);
      total++; if (bus.spawn_ack !== 1'b1) begin bad++; $display("FAIL stall_ack got=%0d want=1", bus.spawn_ack); end
      total++; if (bus.piece_idx !== 3'd5) begin bad++; $display("FAIL stall_piece got=%0d want=5", bus.piece_idx); end
   endtask

   task automatic test_hold();
      hold_reset();
      gen_q = '{3'd2, 3'd4, 3'd1, 3'd6, 3'd3, 3'd5, 3'd5, 3'd5};
      rst_n = 1'b1;
      repeat (7) step();
      bus.spawn_req = 1'b1;
      step();
      bus.spawn_req = 1'b0;
      total++; if (bus.piece_idx !== 3'd2) begin bad++; $display("FAIL hold_setup_piece got=%0d want=2", bus.piece_idx); end
      step();
      step();
      bus.hold_req = 1'b1;
      step();
      bus.hold_req = 1'b0;
      $display("hold1: piece=%0d hold=%0d hv=%0d ack=%0d ha=%0d", bus.piece_idx, bus.hold_idx, bus.hold_valid, bus.spawn_ack, bus.hold_allowed);
      total++; if (bus.hold_idx !== 3'd2) begin bad++; $display("FAIL hold1_idx got=%0d want=2", bus.hold_idx); end
      total++; if (bus.hold_valid !== 1'b1) begin bad++; $display("FAIL hold1_valid got=%0d want=1", bus.hold_valid); end
      total++; if (bus.piece_idx !== 3'd4) begin bad++; $display("FAIL hold1_piece got=%0d want=4", bus.piece_idx); end
      total++; if (bus.spawn_ack !== 1'b1) begin bad++; $display("FAIL hold1_ack got=%0d want=1", bus.spawn_ack); end
      total++; if (bus.hold_allowed !== 1'b0) begin bad++; $display("FAIL hold1_allowed got=%0d want=0", bus.hold_allowed); end
      step();
      step();
      bus.hold_req = 1'b1;
      step();
      bus.hold_req = 1'b0;
      $display("hold2: piece=%0d hold=%0d ack=%0d", bus.piece_idx, bus.hold_idx, bus.spawn_ack);
      total++; if (bus.piece_idx !== 3'd4) begin bad++; $display("FAIL hold2_ignored_piece got=%0d want=4", bus.piece_idx); end
      total++; if (bus.hold_idx !== 3'd2) begin bad++; $display("FAIL hold2_ignored_hold got=%0d want=2", bus.hold_idx); end
      total++; if (bus.spawn_ack !== 1'b0) begin bad++; $display("FAIL hold2_ignored_ack got=%0d want=0", bus.spawn_ack); end
      bus.spawn_req = 1'b1;
      step();
      bus.spawn_req = 1'b0;
      total++; if (bus.piece_idx !== 3'd1) begin bad++; $display("FAIL hold_respawn_piece got=%0d want=1", bus.piece_idx); end
      total++; if (bus.hold_allowed !== 1'b1) begin bad++; $display("FAIL hold_respawn_allowed got=%0d want=1", bus.hold_allowed); end
      step();
      bus.hold_req = 1'b1;
      step();
      bus.hold_req = 1'b0;
      $display("hold3: piece=%0d hold=%0d ack=%0d", bus.piece_idx, bus.hold_idx, bus.spawn_ack);
      total++; if (bus.piece_idx !== 3'd2) begin bad++; $display("FAIL hold3_swap_piece got=%0d want=2", bus.piece_idx); end
      total++; if (bus.hold_idx !== 3'd1) begin bad++; $display("FAIL hold3_swap_hold got=%0d want=1", bus.hold_idx); end
      total++; if (bus.spawn_ack !== 1'b1) begin bad++; $display("FAIL hold3_ack got=%0d want=1", bus.spawn_ack); end
      total++; if (bus.hold_allowed !== 1'b0) begin bad++; $display("FAIL hold3_allowed got=%0d want=0", bus.hold_allowed); end
   endtask

   task automatic test_collision();
      hold_reset();
      gen_q = '{3'd4, 3'd1, 3'd6, 3'd7, 3'd5, 3'd2, 3'd2, 3'd2};
      rst_n = 1'b1;
      repeat (7) step();
      bus.spawn_req = 1'b1;
      step();
      bus.spawn_req = 1'b0;
      step();
      bus.spawn_req = 1'b1;
      step();
      bus.spawn_req = 1'b0;
      $display("collide: piece=%0d cnt=%0d preview=%h", bus.piece_idx, bus.preview_cnt, bus.preview_idx);
      total++; if (bus.piece_idx !== 3'd1) begin bad++; $display("FAIL collide_piece got=%0d want=1", bus.piece_idx); end
      total++; if (bus.preview_cnt !== 2'd2) begin bad++; $display("FAIL collide_cnt got=%0d want=2", bus.preview_cnt); end
      total++; if (bus.preview_idx[0] !== 3'd6 || bus.preview_idx[1] !== 3'd0) begin bad++; $display("FAIL collide_sanitise got=%h want=x06", bus.preview_idx); end
      step();
      step();
      total++; if (bus.preview_cnt !== 2'd3 || bus.preview_idx[2] !== 3'd5) begin bad++; $display("FAIL collide_refill cnt=%0d tail=%0d want cnt=3 tail=5", bus.preview_cnt, bus.preview_idx[2]); end
      bus.spawn_req = 1'b1;
      bus.hold_req  = 1'b1;
      step();
      bus.spawn_req = 1'b0;
      bus.hold_req  = 1'b0;
      $display("priority: piece=%0d ack=%0d hv=%0d ha=%0d", bus.piece_idx, bus.spawn_ack, bus.hold_valid, bus.hold_allowed);
      total++; if (bus.piece_idx !== 3'd6) begin bad++; $display("FAIL prio_piece got=%0d want=6", bus.piece_idx); end
      total++; if (bus.spawn_ack !== 1'b1) begin bad++; $display("FAIL prio_ack got=%0d want=1", bus.spawn_ack); end
      total++; if (bus.hold_valid !== 1'b0) begin bad++; $display("FAIL prio_hold_valid got=%0d want=0", bus.hold_valid); end
      total++; if (bus.hold_allowed !== 1'b1) begin bad++; $display("FAIL prio_hold_allowed got=%0d want=1", bus.hold_allowed); end
   endtask

   task automatic test_async_reset();
      hold_reset();
      gen_q = '{3'd4, 3'd1, 3'd6, 3'd3, 3'd5, 3'd2, 3'd6, 3'd6};
      rst_n = 1'b1;
      repeat (7) step();
      bus.spawn_req = 1'b1;
      step();
      bus.spawn_req = 1'b0;
      step();
      total++; if (bus.gen_new_block !== 1'b1) begin bad++; $display("FAIL areset_in_capt got=%0d want=1", bus.gen_new_block); end
      #1;
      rst_n = 1'b0;
      #1;
      $display("areset: piece=%0d cnt=%0d nb=%0d ha=%0d", bus.piece_idx, bus.preview_cnt, bus.gen_new_block, bus.hold_allowed);
      total++; if (bus.piece_idx !== 3'd0) begin bad++; $display("FAIL areset_piece got=%0d want=0", bus.piece_idx); end
      total++; if (bus.preview_cnt !== 2'd0) begin bad++; $display("FAIL areset_cnt got=%0d want=0", bus.preview_cnt); end
      total++; if (bus.preview_idx !== 9'd0) begin bad++; $display("FAIL areset_preview got=%h want=0", bus.preview_idx); end
      total++; if (bus.gen_new_block !== 1'b0) begin bad++; $display("FAIL areset_new_block got=%0d want=0", bus.gen_new_block); end
      total++; if (bus.hold_allowed !== 1'b1) begin bad++; $display("FAIL areset_allowed got=%0d want=1", bus.hold_allowed); end
      step();
      rst_n = 1'b1;
      repeat (6) step();
      exp_prev = {3'd6, 3'd2, 3'd5};
      $display("areset refill: preview=%h cnt=%0d", bus.preview_idx, bus.preview_cnt);
      total++; if (bus.preview_cnt !== 2'd3) begin bad++; $display("FAIL areset_refill_cnt got=%0d want=3", bus.preview_cnt); end
      total++; if (bus.preview_idx !== exp_prev) begin bad++; $display("FAIL areset_discard got=%h want=%h", bus.preview_idx, exp_prev); end
   endtask

   initial begin
      bus.spawn_req = 1'b0;
      bus.hold_req  = 1'b0;
      test_reset();
      test_reset_fill();
      test_spawn();
      test_empty_stall();
      test_hold();
      test_collision();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
